instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_queue.sv | 62 ++++++
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, the NOP encoding, the fetch FSM state
// type and the queue entry layout used between the fetch unit and its queue.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DROP     = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low two bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, inst} entries between memory and decode.
// Push and pop may happen together even when full; flush wins over both.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (2 or 4).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: issues one word fetch at a time to instruction memory,
// queues returned words with their PC, and handles branch redirects by
// flushing the queue and discarding any response still in flight.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);

  fetch_state_e    state;
  fetch_state_e    next_state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] next_pc;
  logic            req;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  fetch_entry_t    q_head;
  fetch_entry_t    push_data;

  assign push_data = '{pc: fetch_pc, inst: imem_rdata};
  assign pop       = inst_valid && inst_ready;

  // The queue always has room for the one outstanding fetch, since a request
  // is only issued when it is not full and nothing else pushes meanwhile.
  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .flush    (redirect_valid),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Fetch state and PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= next_state;
      fetch_pc <= next_pc;
    end
  end

  // Next-state, next-PC, request and push decisions.
  always_comb begin
    next_state = state;
    next_pc    = fetch_pc;
    req        = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        // A redirect this cycle would make any request stale, so hold off.
        if (redirect_valid) begin
          next_pc = align_pc(redirect_pc);
        end else if (!q_full) begin
          req        = 1'b1;
          next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        req = 1'b1;
        if (imem_ack) begin
          next_state = IDLE;
          if (redirect_valid) begin
            next_pc = align_pc(redirect_pc);
          end else begin
            push    = 1'b1;
            next_pc = fetch_pc + 32'd4;
          end
        end else if (redirect_valid) begin
          next_state = DROP;
          next_pc    = align_pc(redirect_pc);
        end
      end
      DROP: begin
        // Waiting out the stale response; later redirects only retarget the PC.
        if (redirect_valid) next_pc = align_pc(redirect_pc);
        if (imem_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign imem_req   = req && !reset;
  assign imem_addr  = fetch_pc;
  assign inst_valid = !q_empty;
  assign inst_out   = q_empty ? INST_NOP : q_head.inst;
  assign inst_pc    = q_empty ? '0 : q_head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a reactive memory model, a queue-based
// reference model checked every cycle, and directed scenarios with literal
// expectations. A second instance exercises RESET_PC wrap and QDEPTH=4.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  localparam int          QD   = 2;
  localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  logic        req2;
  logic [31:0] addr2;
  logic        ack2 = 1'b0;
  logic [31:0] rdata2 = '0;
  logic        valid2;
  logic [31:0] out2;
  logic [31:0] pc2;

  // values to apply in the next cycle
  logic        reset_n = 1'b1, redirect_n = 1'b0, ready_n = 1'b0, stray_n = 1'b0;
  logic [31:0] rpc_n = '0;
  logic        ack_next = 1'b0, ack2_next = 1'b0, ack_q = 1'b0;
  logic [31:0] rdata_next = '0, rdata2_next = '0;

  // reference model / memory state
  logic [63:0] mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          busy = 0, killed = 0, done = 0, exp_req = 0, exp_valid = 0;
  int          cnt = 0;
  int          lat = 1;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_log[$];
  logic [63:0] pop_log[$];
  logic [31:0] cap2_log[$];
  logic [31:0] pop2_log[$];

  int n_cmp = 0;
  int n_err = 0;
  int c1, p1;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  instruction_fetch_unit #(.RESET_PC(RPC2), .QDEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .inst_valid(valid2), .inst_out(out2),
    .inst_pc(pc2), .inst_ready(1'b1)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_log32(input string name, input int idx, input logic [31:0] exp);
    if (idx < cap_log.size()) chk(name, 64'(cap_log[idx]), 64'(exp));
    else chk(name, 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp));
  endtask

  task automatic chk_pop(input string name, input int idx, input logic [63:0] exp);
    if (idx < pop_log.size()) chk(name, pop_log[idx], exp);
    else chk(name, 64'hFFFF_FFFF_FFFF_FFFF, exp);
  endtask

  task automatic chk_log2(input string name, input bit cap, input int idx, input logic [31:0] exp);
    if (cap && idx < cap2_log.size()) chk(name, 64'(cap2_log[idx]), 64'(exp));
    else if (!cap && idx < pop2_log.size()) chk(name, 64'(pop2_log[idx]), 64'(exp));
    else chk(name, 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_cap(input int c0);
    int k = 0;
    while (cap_log.size() <= c0 && k < 50) begin
      step(1);
      k++;
    end
    if (cap_log.size() <= c0) chk("wait_capture_timeout", 64'(cap_log.size()), 64'(c0 + 1));
  endtask

  // apply all DUT inputs just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    reset          = reset_n;
    redirect_valid = redirect_n;
    redirect_pc    = rpc_n;
    inst_ready     = ready_n;
    ack_q          = ack_next;
    imem_ack       = ack_next | stray_n;
    imem_rdata     = stray_n ? 32'hDEAD_BEEF : rdata_next;
    ack2           = ack2_next;
    rdata2         = rdata2_next;
  end

  // per-cycle check of the main DUT, then advance model and memory
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_req", 64'(imem_req), 64'h0);
      chk("rst_addr", 64'(imem_addr), 64'h0);
      chk("rst_valid", 64'(inst_valid), 64'h0);
      chk("rst_inst", 64'(inst_out), 64'h13);
      chk("rst_pc", 64'(inst_pc), 64'h0);
      mq.delete();
      m_pc = 32'h0; busy = 0; killed = 0; ack_next = 1'b0;
    end else begin
      exp_valid = (mq.size() != 0);
      chk("inst_valid", 64'(inst_valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("inst_out", 64'(inst_out), 64'(mq[0][31:0]));
        chk("inst_pc", 64'(inst_pc), 64'(mq[0][63:32]));
      end else begin
        chk("idle_inst", 64'(inst_out), 64'(INST_NOP));
        chk("idle_pc", 64'(inst_pc), 64'h0);
      end
      exp_req = busy ? !killed : (mq.size() < QD && !redirect_valid);
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(busy ? cap_addr : m_pc));
      if (inst_valid && inst_ready) pop_log.push_back({inst_pc, inst_out});

      if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
      done = 0;
      ack_next = 1'b0;
      if (busy && ack_q) begin
        if (!killed && !redirect_valid) begin
          mq.push_back({cap_addr, inst_of(cap_addr)});
          m_pc = cap_addr + 32'd4;
        end
        busy = 0;
        done = 1;
      end else if (busy) begin
        cnt--;
        ack_next = (cnt == 0);
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (busy) killed = 1;
      end
      if (!busy && !done && imem_req) begin
        busy = 1; killed = 0;
        cap_addr = imem_addr;
        cap_log.push_back(imem_addr);
        cnt = lat - 1;
        ack_next = (cnt == 0);
        rdata_next = inst_of(imem_addr);
      end
    end
  end

  // second instance: fixed latency-1 memory, always ready
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst2_req", 64'(req2), 64'h0);
      chk("rst2_addr", 64'(addr2), 64'(RPC2));
      chk("rst2_valid", 64'(valid2), 64'h0);
      ack2_next = 1'b0;
    end else begin
      if (valid2) begin
        pop2_log.push_back(pc2);
        chk("dut2_inst", 64'(out2), 64'(inst_of(pc2)));
      end
      if (req2 && !ack2) begin
        cap2_log.push_back(addr2);
        ack2_next = 1'b1;
        rdata2_next = inst_of(addr2);
      end else begin
        ack2_next = 1'b0;
      end
    end
  end

  initial begin
    step(3);
    // streaming from reset, latency 1, decode always ready
    lat = 1; ready_n = 1'b1; reset_n = 1'b0;
    step(12);
    chk_log32("seq_addr0", 0, 32'h0);
    chk_log32("seq_addr1", 1, 32'h4);
    chk_log32("seq_addr2", 2, 32'h8);
    chk_pop("seq_pop0", 0, {32'h0, 32'h5A5A_5A5A});
    chk_pop("seq_pop1", 1, {32'h4, 32'h5A5A_5A5E});
    chk_pop("seq_pop2", 2, {32'h8, 32'h5A5A_5A52});

    // decode stalls: queue fills to depth and requests stop
    ready_n = 1'b0;
    step(10);
    chk("stall_req", 64'(imem_req), 64'h0);
    chk("stall_valid", 64'(inst_valid), 64'h1);
    chk("stall_model_depth", 64'(mq.size()), 64'd2);
    ready_n = 1'b1;
    step(6);

    // redirect while a request is in flight: response dropped
    lat = 3;
    wait_cap(cap_log.size());
    rpc_n = 32'h0000_0100; redirect_n = 1'b1;
    step(1);
    redirect_n = 1'b0;
    step(1);
    c1 = cap_log.size(); p1 = pop_log.size();
    step(15);
    chk_log32("drop_next_addr", c1, 32'h100);
    chk_pop("drop_first_inst", p1, {32'h100, 32'h5A5A_5B5A});

    // redirect to an unaligned target coincident with the ack
    lat = 2;
    wait_cap(cap_log.size());
    rpc_n = 32'h0000_0102; redirect_n = 1'b1;
    step(1);
    chk("coinc_ack_present", 64'(imem_ack), 64'h1);
    redirect_n = 1'b0;
    step(1);
    c1 = cap_log.size(); p1 = pop_log.size();
    step(12);
    chk_log32("coinc_next_addr", c1, 32'h100);
    chk_pop("coinc_first_inst", p1, {32'h100, 32'h5A5A_5B5A});

    // reset mid-transaction, then a stray ack right after release
    lat = 3;
    wait_cap(cap_log.size());
    reset_n = 1'b1;
    step(2);
    reset_n = 1'b0; stray_n = 1'b1;
    c1 = cap_log.size(); p1 = pop_log.size();
    step(1);
    stray_n = 1'b0;
    chk("stray_ack_seen", 64'(imem_ack), 64'h1);
    chk("stray_valid0", 64'(inst_valid), 64'h0);
    step(1);
    chk("stray_valid1", 64'(inst_valid), 64'h0);
    step(10);
    chk_log32("post_reset_addr", c1, 32'h0);
    chk_pop("post_reset_inst", p1, {32'h0, 32'h5A5A_5A5A});

    // RESET_PC near the top of the address space wraps to zero
    chk_log2("wrap_addr0", 1, 0, 32'hFFFF_FFF8);
    chk_log2("wrap_addr1", 1, 1, 32'hFFFF_FFFC);
    chk_log2("wrap_addr2", 1, 2, 32'h0000_0000);
    chk_log2("wrap_pop0", 0, 0, 32'hFFFF_FFF8);
    chk_log2("wrap_pop1", 0, 1, 32'hFFFF_FFFC);
    chk_log2("wrap_pop2", 0, 2, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
